// File: rtl/sr_flag_arbiter_if.sv
// Grant bus between the SR flag arbiter and its requesters/consumer.
// The master side drives set/reset/done; the slave side reports flags and grant.
interface sr_flag_arbiter_if #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
);
    logic [N-1:0]   s;
    logic [N-1:0]   r;
    logic [N-1:0]   flags;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;
    logic           done;
    logic           busy;
    logic           timeout_err;

    modport master (
        output s, r, done,
        input  flags, gnt_valid, gnt_id, busy, timeout_err
    );

    modport slave (
        input  s, r, done,
        output flags, gnt_valid, gnt_id, busy, timeout_err
    );
endinterface

// File: rtl/sr_flag_arbiter.sv
// Sticky SR request flags with a round-robin single-grant scheduler.
// Grants end on done, on the flag being dropped, or on a cycle timeout.
module sr_flag_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 15
) (
    input logic           clk,
    input logic           reset,
    sr_flag_arbiter_if.slave bus
);
    localparam int IDW = $clog2(N);
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TLAST = TW'(TIMEOUT - 1);
    localparam logic [IDW-1:0] IDMAX = IDW'(N - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state;
    logic [N-1:0]   flags_q;
    logic [N-1:0]   flags_d;
    logic [N-1:0]   clr;
    logic           gnt_valid_q;
    logic [IDW-1:0] gnt_id_q;
    logic           busy_q;
    logic           to_q;
    logic [IDW-1:0] ptr;
    logic [TW-1:0]  timer;
    logic [IDW-1:0] pick;
    logic [IDW-1:0] cand;
    logic [IDW-1:0] nxt;

    assign nxt = (gnt_id_q == IDMAX) ? '0 : gnt_id_q + 1'b1;

    // Walk downward so the closest set bit at/after ptr is the last one kept.
    always_comb begin
        pick = '0;
        cand = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = IDW'((int'(ptr) + k) % N);
            if (flags_q[cand]) pick = cand;
        end
    end

    // Completion clears the granted bit; a same-cycle set still wins below.
    always_comb begin
        clr = '0;
        if (state == GRANT) begin
            if (bus.done)
                clr[gnt_id_q] = 1'b1;
            else if (flags_q[gnt_id_q] && timer == TLAST)
                clr[gnt_id_q] = 1'b1;
        end
        flags_d = (bus.s & ~bus.r) | (flags_q & ~bus.r & ~clr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            flags_q     <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            busy_q      <= 1'b0;
            to_q        <= 1'b0;
            ptr         <= '0;
            timer       <= '0;
        end else begin
            flags_q <= flags_d;
            to_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (|flags_q) begin
                        gnt_id_q    <= pick;
                        gnt_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        timer       <= '0;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    if (bus.done) begin
                        ptr         <= nxt;
                        gnt_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end else if (!flags_q[gnt_id_q]) begin
                        gnt_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end else if (timer == TLAST) begin
                        ptr         <= nxt;
                        to_q        <= 1'b1;
                        gnt_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.flags       = flags_q;
    assign bus.gnt_valid   = gnt_valid_q;
    assign bus.gnt_id      = gnt_id_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = to_q;
endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Bench for sr_flag_arbiter: directed scenarios plus random traffic
// compared every cycle against a grant-level behavioural model.
module tb_sr_flag_arbiter;
    localparam int N  = 4;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int total = 0;
    int bad = 0;

    sr_flag_arbiter_if #(.N(N)) bus ();

    sr_flag_arbiter #(.N(N), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: pending set, current grant (-1 = none), age of grant.
    bit [N-1:0] mf;
    int mg;
    int mptr;
    int mage;
    bit mto;

    task automatic model_reset();
        mf = '0;
        mg = -1;
        mptr = 0;
        mage = 0;
        mto = 0;
    endtask

    task automatic model_step(input bit [N-1:0] sv, input bit [N-1:0] rv, input bit dv);
        bit [N-1:0] old;
        int victim;
        old = mf;
        victim = -1;
        mto = 0;
        if (mg < 0) begin
            for (int k = 0; k < N; k++) begin
                if (mg < 0 && old[(mptr + k) % N]) begin
                    mg = (mptr + k) % N;
                    mage = 0;
                end
            end
        end else if (dv) begin
            victim = mg;
            mptr = (mg + 1) % N;
            mg = -1;
        end else if (!old[mg]) begin
            mg = -1;
        end else if (mage == TO - 1) begin
            victim = mg;
            mto = 1;
            mptr = (mg + 1) % N;
            mg = -1;
        end else begin
            mage++;
        end
        for (int i = 0; i < N; i++) begin
            if (sv[i] && !rv[i]) mf[i] = 1'b1;
            else if (rv[i]) mf[i] = 1'b0;
            else if (i == victim) mf[i] = 1'b0;
            else mf[i] = old[i];
        end
    endtask

    task automatic cycle(input logic [N-1:0] sv, input logic [N-1:0] rv, input logic dv);
        bus.s = sv;
        bus.r = rv;
        bus.done = dv;
        @(posedge clk);
        model_step(sv, rv, dv);
        #1;
        bus.s = '0;
        bus.r = '0;
        bus.done = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.s = '0;
        bus.r = '0;
        bus.done = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.s = 4'hF;
        bus.r = '0;
        bus.done = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.flags !== 4'h0 || bus.gnt_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.gnt_id !== 2'd0 || bus.timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold got flags=%h v=%b busy=%b id=%0d to=%b exp 0",
                     bus.flags, bus.gnt_valid, bus.busy, bus.gnt_id, bus.timeout_err);
        end
        reset = 1'b1;
        cycle(4'hF, 4'h0, 1'b0);
        total++;
        if (bus.flags !== 4'hF) begin
            bad++;
            $display("FAIL reset_release flags got=%h exp=f", bus.flags);
        end
        do_reset();
    endtask

    task automatic test_single();
        cycle(4'b0100, 4'h0, 1'b0);
        total++;
        if (bus.flags !== 4'b0100 || bus.gnt_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_set flags=%b v=%b exp 0100/0", bus.flags, bus.gnt_valid);
        end
        cycle(4'h0, 4'h0, 1'b0);
        total++;
        if (bus.gnt_valid !== 1'b1 || bus.gnt_id !== 2'd2 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL single_grant v=%b id=%0d busy=%b exp 1/2/1",
                     bus.gnt_valid, bus.gnt_id, bus.busy);
        end
        cycle(4'h0, 4'h0, 1'b1);
        total++;
        if (bus.flags !== 4'h0 || bus.gnt_valid !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL single_done flags=%b v=%b busy=%b exp 0/0/0",
                     bus.flags, bus.gnt_valid, bus.busy);
        end
    endtask

    task automatic test_round_robin();
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        do_reset();
        cycle(4'hF, 4'h0, 1'b0);
        for (int g = 0; g < 5; g++) begin
            cycle(4'h0, 4'h0, 1'b0);
            total++;
            if (bus.gnt_valid !== 1'b1 || int'(bus.gnt_id) != exp_seq[g]) begin
                bad++;
                $display("FAIL rr_id[%0d] v=%b id=%0d exp=%0d",
                         g, bus.gnt_valid, bus.gnt_id, exp_seq[g]);
            end
            cycle((g == 3) ? 4'b0001 : 4'h0, 4'h0, 1'b0);
            cycle(4'h0, 4'h0, 1'b0);
            cycle(4'h0, 4'h0, 1'b1);
            total++;
            if (bus.flags[exp_seq[g]] !== 1'b0 || bus.gnt_valid !== 1'b0) begin
                bad++;
                $display("FAIL rr_clear[%0d] flags=%b v=%b", g, bus.flags, bus.gnt_valid);
            end
        end
    endtask

    task automatic test_set_vs_done();
        do_reset();
        cycle(4'b0010, 4'b0010, 1'b0);
        total++;
        if (bus.flags[1] !== 1'b0) begin
            bad++;
            $display("FAIL sr_reset_wins flags=%b exp bit1=0", bus.flags);
        end
        cycle(4'b1010, 4'h0, 1'b0);
        cycle(4'h0, 4'h0, 1'b0);
        total++;
        if (bus.gnt_valid !== 1'b1 || bus.gnt_id !== 2'd1) begin
            bad++;
            $display("FAIL svd_grant1 v=%b id=%0d exp 1/1", bus.gnt_valid, bus.gnt_id);
        end
        cycle(4'b0010, 4'h0, 1'b1);
        total++;
        if (bus.flags !== 4'b1010 || bus.gnt_valid !== 1'b0) begin
            bad++;
            $display("FAIL svd_keep flags=%b v=%b exp 1010/0", bus.flags, bus.gnt_valid);
        end
        cycle(4'h0, 4'h0, 1'b0);
        total++;
        if (bus.gnt_id !== 2'd3 || bus.gnt_valid !== 1'b1) begin
            bad++;
            $display("FAIL svd_next id=%0d v=%b exp 3/1", bus.gnt_id, bus.gnt_valid);
        end
        cycle(4'h0, 4'h0, 1'b1);
        cycle(4'h0, 4'h0, 1'b0);
        total++;
        if (bus.gnt_id !== 2'd1 || bus.gnt_valid !== 1'b1) begin
            bad++;
            $display("FAIL svd_regrant id=%0d v=%b exp 1/1", bus.gnt_id, bus.gnt_valid);
        end
        cycle(4'h0, 4'h0, 1'b1);
    endtask

    task automatic test_timeout();
        do_reset();
        cycle(4'b1000, 4'h0, 1'b0);
        cycle(4'h0, 4'h0, 1'b0);
        total++;
        if (bus.gnt_id !== 2'd3 || bus.gnt_valid !== 1'b1) begin
            bad++;
            $display("FAIL to_grant id=%0d v=%b exp 3/1", bus.gnt_id, bus.gnt_valid);
        end
        for (int i = 1; i < TO; i++) begin
            cycle((i == 2) ? 4'b0001 : 4'h0, 4'h0, 1'b0);
            total++;
            if (bus.timeout_err !== 1'b0 || bus.gnt_valid !== 1'b1) begin
                bad++;
                $display("FAIL to_early[%0d] to=%b v=%b exp 0/1",
                         i, bus.timeout_err, bus.gnt_valid);
            end
        end
        cycle(4'h0, 4'h0, 1'b0);
        total++;
        if (bus.timeout_err !== 1'b1 || bus.flags[3] !== 1'b0 || bus.gnt_valid !== 1'b0) begin
            bad++;
            $display("FAIL to_fire to=%b flags=%b v=%b exp 1/0xxx/0",
                     bus.timeout_err, bus.flags, bus.gnt_valid);
        end
        cycle(4'h0, 4'h0, 1'b0);
        total++;
        if (bus.timeout_err !== 1'b0 || bus.gnt_valid !== 1'b1 || bus.gnt_id !== 2'd0) begin
            bad++;
            $display("FAIL to_after to=%b v=%b id=%0d exp 0/1/0",
                     bus.timeout_err, bus.gnt_valid, bus.gnt_id);
        end
    endtask

    task automatic test_drop_and_async();
        do_reset();
        cycle(4'b0001, 4'h0, 1'b0);
        cycle(4'h0, 4'h0, 1'b0);
        cycle(4'h0, 4'b0001, 1'b0);
        cycle(4'h0, 4'h0, 1'b0);
        total++;
        if (bus.gnt_valid !== 1'b0 || bus.timeout_err !== 1'b0 || bus.flags[0] !== 1'b0) begin
            bad++;
            $display("FAIL drop v=%b to=%b flags=%b exp 0/0/xxx0",
                     bus.gnt_valid, bus.timeout_err, bus.flags);
        end
        cycle(4'b0010, 4'h0, 1'b0);
        cycle(4'h0, 4'h0, 1'b0);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        total++;
        if (bus.gnt_valid !== 1'b0 || bus.busy !== 1'b0 || bus.flags !== 4'h0 ||
            bus.gnt_id !== 2'd0) begin
            bad++;
            $display("FAIL async_reset v=%b busy=%b flags=%b id=%0d exp 0",
                     bus.gnt_valid, bus.busy, bus.flags, bus.gnt_id);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_random();
        logic [N-1:0] sv;
        logic [N-1:0] rv;
        logic dv;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                sv[i] = ($urandom_range(0, 5) == 0);
                rv[i] = ($urandom_range(0, 19) == 0);
            end
            dv = ($urandom_range(0, 7) == 0);
            cycle(sv, rv, dv);
            total++;
            if (bus.flags !== mf || bus.gnt_valid !== (mg >= 0) ||
                bus.busy !== (mg >= 0) || bus.timeout_err !== mto ||
                (mg >= 0 && int'(bus.gnt_id) != mg)) begin
                bad++;
                $display("FAIL rand[%0d] got f=%b v=%b id=%0d b=%b to=%b exp f=%b g=%0d to=%b",
                         c, bus.flags, bus.gnt_valid, bus.gnt_id, bus.busy,
                         bus.timeout_err, mf, mg, mto);
            end
        end
    endtask

    initial begin
        bus.s = '0;
        bus.r = '0;
        bus.done = 1'b0;
        model_reset();
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_set_vs_done();
        test_timeout();
        test_drop_and_async();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
